cv32e40p_rf_wb_arbiter: RTL
===========================

// Module: cv32e40p_rf_wb_arbiter
// PURPOSE
//  Shares the integer register file's single write port between two writeback sources: EX (ALU/MULT) and LSU (load data).
//  Registers the winning write for one cycle, then drives the register file write port.
//  Keeps a per-register scoreboard of outstanding loads.
//  Reports read-after-write hazards for the three read ports (a/b/c) to the ID stage.
// PARAMETERS
//  STARVE_LIMIT  4  max consecutive LSU grants while EX waits; the next grant is forced to EX (1..15)
//  MAX_LOADS     2  max outstanding loads per destination register (per-register counter width = 2 bits)
// PORTS
//  clk               in   1   clock
//  rst_n             in   1   asynchronous active-low reset
//  ex_valid_i        in   1   EX writeback request
//  ex_ready_o        out  1   EX request granted this cycle (combinational)
//  ex_waddr_i        in   5   EX destination register
//  ex_wdata_i        in   32  EX result
//  lsu_valid_i       in   1   LSU load-data writeback request
//  lsu_ready_o       out  1   LSU request granted this cycle (combinational)
//  lsu_waddr_i       in   5   LSU destination register
//  lsu_wdata_i       in   32  load data
//  lsu_issue_i       in   1   load issued to memory; marks its destination as pending
//  lsu_issue_addr_i  in   5   destination register of the issued load
//  raddr_a_i/b/c_i   in   5   ID-stage read addresses
//  hazard_a_o/b/c_o  out  1   the matching read address must stall (combinational)
//  rf_we_o           out  1   register file write enable (registered)
//  rf_waddr_o        out  5   register file write address (registered)
//  rf_wdata_o        out  32  register file write data (registered)
//  pending_o         out  32  bit r = 1 while any load to register r is outstanding
// BEHAVIOUR
//  Reset (async): rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, starve counter=0, all scoreboard counters=0, pending_o=0.
//  Reset mid-operation: any in-flight write stage and all outstanding-load state are discarded.
//  Handshake: a transfer occurs when valid&ready; ready never depends on its own valid.
//  The write port never back-pressures, so one transfer at most per cycle is always granted.
//  Arbitration:
//   - Default priority is LSU.
//   - EX wins if lsu_valid_i=0, or if ex_valid_i=1 and the starve counter equals STARVE_LIMIT.
//   - The loser sees ready=0 and must hold its request stable.
//  Starve counter:
//   - +1 when LSU is granted while ex_valid_i=1.
//   - Cleared when EX is granted or ex_valid_i=0.
//   - Saturates at STARVE_LIMIT.
//  Latency: a transfer in cycle N drives rf_we_o/waddr/wdata in cycle N+1; the register file captures at the end of N+1.
//  When no transfer occurs, rf_we_o=0 in the next cycle; waddr/wdata hold their previous values.
//  x0 writes: the handshake completes normally, but rf_we_o=0 for that slot.
//  Scoreboard (2-bit counter per register 1..31; x0 is never tracked):
//   - lsu_issue_i: counter +1. An issue at MAX_LOADS is an illegal stimulus (assertion); the counter holds.
//   - LSU transfer: counter of lsu_waddr_i -1. A transfer at count 0 is an illegal stimulus (assertion).
//   - Issue and transfer to the same register in the same cycle: counter unchanged.
//   - pending_o[r] = (count[r] != 0).
//  Hazard: hazard_x_o = (raddr_x != 0) & (pending_o[raddr_x] | (rf_we_o & rf_waddr_o == raddr_x)).
//   - Write-stage bypassing is not provided; the core stalls one cycle instead.
//  EX writes to a register with a pending load are not blocked here; ID prevents that WAW case.
// TESTING
//  1. Reset, then EX only: ex_valid=1, waddr=5, wdata=0xDEADBEEF -> ex_ready=1 same cycle; next cycle rf_we=1, waddr=5, wdata=0xDEADBEEF.
//  2. Collision: EX(r3) and LSU(r4) both valid every cycle, STARVE_LIMIT=4 -> grants LSU,LSU,LSU,LSU,EX repeating; EX data is never lost.
//  3. Scoreboard: issue r7 twice, then two LSU writebacks to r7 -> pending_o[7]=1 until the second transfer; hazard_a=1 while raddr_a=7; 0 after the write-stage cycle.
//  4. Same-cycle issue and writeback to r9 at count 1 -> count stays 1 and pending_o[9] stays 1.
//  5. x0: EX write to r0 with data 0x1234 -> ex_ready=1, rf_we stays 0; issue to r0 leaves pending_o=0; hazard_a=0 for raddr_a=0.
//  6. Async reset asserted while rf_we=1 and pending_o=0x80 -> all outputs 0 immediately; they stay 0 after release until a new transfer.

Source files
------------

// File: rtl/cv32e40p_rf_wb_arbiter.sv
// Register file writeback arbiter: shares the single integer register file write port
// between EX and LSU writebacks, registers the winning write for one cycle, tracks
// outstanding loads per destination register and flags read-after-write hazards to ID.
module cv32e40p_rf_wb_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned MAX_LOADS    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid_i,
    output logic        ex_ready_o,
    input  logic [4:0]  ex_waddr_i,
    input  logic [31:0] ex_wdata_i,
    input  logic        lsu_valid_i,
    output logic        lsu_ready_o,
    input  logic [4:0]  lsu_waddr_i,
    input  logic [31:0] lsu_wdata_i,
    input  logic        lsu_issue_i,
    input  logic [4:0]  lsu_issue_addr_i,
    input  logic [4:0]  raddr_a_i,
    input  logic [4:0]  raddr_b_i,
    input  logic [4:0]  raddr_c_i,
    output logic        hazard_a_o,
    output logic        hazard_b_o,
    output logic        hazard_c_o,
    output logic        rf_we_o,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o,
    output logic [31:0] pending_o
);

    localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);
    localparam logic [1:0] LoadMax   = 2'(MAX_LOADS);

    logic [3:0]  starve_q, starve_d;
    logic        starved;
    logic        ex_xfer, lsu_xfer;
    logic        we_q;
    logic [4:0]  waddr_q;
    logic [31:0] wdata_q;
    logic [1:0]  cnt_q [32];
    logic [1:0]  cnt_d [32];
    logic [31:0] pending;

    // Grant decode: LSU has priority unless EX has been starved for STARVE_LIMIT grants.
    // Each ready looks only at the other side's request, never at its own valid.
    always_comb begin
        starved     = (starve_q == StarveMax);
        ex_ready_o  = ~lsu_valid_i | starved;
        lsu_ready_o = ~(ex_valid_i & starved);
        ex_xfer     = ex_valid_i & ex_ready_o;
        lsu_xfer    = lsu_valid_i & lsu_ready_o;
    end

    // Starve counter next state: counts LSU grants that bypassed a waiting EX request.
    always_comb begin
        starve_d = starve_q;
        if (ex_xfer || !ex_valid_i) begin
            starve_d = 4'd0;
        end else if (lsu_xfer && !starved) begin
            starve_d = starve_q + 4'd1;
        end
    end

    // Starve counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= 4'd0;
        end else begin
            starve_q <= starve_d;
        end
    end

    // Write stage: capture the granted transfer; x0 completes the handshake without a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            waddr_q <= 5'd0;
            wdata_q <= 32'd0;
        end else if (ex_xfer) begin
            we_q    <= (ex_waddr_i != 5'd0);
            waddr_q <= ex_waddr_i;
            wdata_q <= ex_wdata_i;
        end else if (lsu_xfer) begin
            we_q    <= (lsu_waddr_i != 5'd0);
            waddr_q <= lsu_waddr_i;
            wdata_q <= lsu_wdata_i;
        end else begin
            we_q    <= 1'b0;
        end
    end

    assign rf_we_o    = we_q;
    assign rf_waddr_o = waddr_q;
    assign rf_wdata_o = wdata_q;

    // Scoreboard next state: issue increments, LSU writeback decrements, both cancel out.
    always_comb begin
        logic inc, dec;
        for (int r = 0; r < 32; r++) begin
            inc      = lsu_issue_i && (lsu_issue_addr_i == 5'(r)) && (r != 0);
            dec      = lsu_xfer && (lsu_waddr_i == 5'(r)) && (r != 0);
            cnt_d[r] = cnt_q[r];
            if (inc && !dec && (cnt_q[r] != LoadMax)) begin
                cnt_d[r] = cnt_q[r] + 2'd1;
            end else if (dec && !inc && (cnt_q[r] != 2'd0)) begin
                cnt_d[r] = cnt_q[r] - 2'd1;
            end
        end
    end

    // Scoreboard counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 32; r++) begin
                cnt_q[r] <= 2'd0;
            end
        end else begin
            for (int r = 0; r < 32; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    // Pending flags and hazards; no write-stage bypass, so a write in flight also stalls.
    always_comb begin
        for (int r = 0; r < 32; r++) begin
            pending[r] = (cnt_q[r] != 2'd0);
        end
        pending_o  = pending;
        hazard_a_o = (raddr_a_i != 5'd0) & (pending[raddr_a_i] | (we_q & (waddr_q == raddr_a_i)));
        hazard_b_o = (raddr_b_i != 5'd0) & (pending[raddr_b_i] | (we_q & (waddr_q == raddr_b_i)));
        hazard_c_o = (raddr_c_i != 5'd0) & (pending[raddr_c_i] | (we_q & (waddr_q == raddr_c_i)));
    end

    // Illegal stimulus: issuing beyond MAX_LOADS, or a load writeback with nothing outstanding.
    a_issue_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(lsu_issue_i && (lsu_issue_addr_i != 5'd0) && (cnt_q[lsu_issue_addr_i] == LoadMax)));
    a_xfer_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(lsu_xfer && (lsu_waddr_i != 5'd0) && (cnt_q[lsu_waddr_i] == 2'd0)));

endmodule
